// File: rtl/csr_stream_pkg.sv
// Shared types and CSR map for the CSR stream buffer: FSM states, word
// addresses and STATUS bit positions.
package csr_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned ADDR_CTRL     = 0;
    localparam int unsigned ADDR_STATUS   = 1;
    localparam int unsigned ADDR_LEN      = 2;
    localparam int unsigned ADDR_ISSUED   = 3;
    localparam int unsigned ADDR_IN_LANE  = 8;
    localparam int unsigned ADDR_OUT_LANE = 16;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_FLUSH = 1;

    localparam int unsigned ST_IN_EMPTY  = 0;
    localparam int unsigned ST_IN_FULL   = 1;
    localparam int unsigned ST_OUT_EMPTY = 2;
    localparam int unsigned ST_OUT_FULL  = 3;
    localparam int unsigned ST_RUNNING   = 4;
    localparam int unsigned ST_DONE      = 5;
    localparam int unsigned ST_OVERFLOW  = 8;
    localparam int unsigned ST_UNDERFLOW = 9;
    localparam int unsigned ST_COUNT_LSB = 16;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDRSIZE = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [WIDTH-1:0]    wdata_i,
    output logic [WIDTH-1:0]    rdata_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [ADDRSIZE:0]   count_o
);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [ADDRSIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRSIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRSIZE:0]   count_q, count_d;
    logic                do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (ADDRSIZE+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + ADDRSIZE'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + ADDRSIZE'(1);
        if (do_push && !do_pop)      count_d = count_q + (ADDRSIZE+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (ADDRSIZE+1)'(1);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/csr_stream_buffer.sv
// Avalon-MM CSR slave staging host words into an engine input FIFO and
// collecting engine results in an output FIFO, sequenced by a job FSM.
module csr_stream_buffer
    import csr_stream_pkg::*;
#(
    parameter int unsigned SLAVE_ADDRESSWIDTH = 5,
    parameter int unsigned DATAWIDTH          = 32,
    parameter int unsigned WORDWIDTH          = 64,
    parameter int unsigned DEPTH              = 16,
    parameter int unsigned ADDRSIZE           = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [SLAVE_ADDRESSWIDTH-1:0] slave_address,
    input  logic [DATAWIDTH-1:0]          slave_writedata,
    input  logic                          slave_write,
    input  logic                          slave_read,
    input  logic                          slave_chipselect,
    output logic [DATAWIDTH-1:0]          slave_readdata,
    output logic                          eng_start,
    output logic [WORDWIDTH-1:0]          eng_in_data,
    output logic                          eng_in_valid,
    input  logic                          eng_in_ready,
    input  logic [WORDWIDTH-1:0]          eng_out_data,
    input  logic                          eng_out_valid,
    output logic                          eng_out_ready
);

    localparam int unsigned LANES = WORDWIDTH / DATAWIDTH;
    localparam int unsigned AW    = SLAVE_ADDRESSWIDTH;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] readdata_q, rdata_d;
    logic [WORDWIDTH-1:0] shadow_q, in_wdata, out_rdata;
    logic [15:0]          len_q, issued_q, recv_q;
    logic                 eng_start_q, done_q, ovf_q, udf_q;
    logic                 wr, rd, start_req, flush_req, status_wr;
    logic                 in_push_req, out_pop_req, start_job, job_end;
    logic                 in_pop, out_push;
    logic                 in_empty, in_full, out_empty, out_full;
    logic [ADDRSIZE:0]    in_count, out_count;
    logic [31:0]          status_w;

    // A write wins over a simultaneous read.
    assign wr          = slave_chipselect && slave_write;
    assign rd          = slave_chipselect && slave_read && !slave_write;
    assign start_req   = wr && (slave_address == AW'(ADDR_CTRL)) && slave_writedata[CTRL_START];
    assign flush_req   = wr && (slave_address == AW'(ADDR_CTRL)) && slave_writedata[CTRL_FLUSH];
    assign status_wr   = wr && (slave_address == AW'(ADDR_STATUS));
    assign in_push_req = wr && (slave_address == AW'(ADDR_IN_LANE + LANES - 1));
    assign out_pop_req = rd && (slave_address == AW'(ADDR_OUT_LANE + LANES - 1));
    assign in_pop      = eng_in_valid && eng_in_ready;
    assign out_push    = eng_out_ready && eng_out_valid;

    always_comb begin
        in_wdata = shadow_q;
        in_wdata[(LANES-1)*DATAWIDTH +: DATAWIDTH] = slave_writedata;
    end

    sync_fifo #(.WIDTH(WORDWIDTH), .DEPTH(DEPTH), .ADDRSIZE(ADDRSIZE)) u_in_fifo (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_req),
        .push_i(in_push_req), .pop_i(in_pop), .wdata_i(in_wdata), .rdata_o(eng_in_data),
        .full_o(in_full), .empty_o(in_empty), .count_o(in_count)
    );

    sync_fifo #(.WIDTH(WORDWIDTH), .DEPTH(DEPTH), .ADDRSIZE(ADDRSIZE)) u_out_fifo (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_req),
        .push_i(out_push), .pop_i(out_pop_req), .wdata_i(eng_out_data), .rdata_o(out_rdata),
        .full_o(out_full), .empty_o(out_empty), .count_o(out_count)
    );

    always_comb begin
        state_d       = state_q;
        start_job     = 1'b0;
        job_end       = 1'b0;
        eng_in_valid  = 1'b0;
        eng_out_ready = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_req && len_q != '0) begin
                    state_d   = RUN;
                    start_job = 1'b1;
                end
            end
            RUN: begin
                eng_in_valid  = !in_empty && (issued_q < len_q);
                eng_out_ready = !out_full;
                if (eng_out_ready && eng_out_valid && (recv_q + 16'd1 == len_q)) begin
                    state_d = DONE;
                    job_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_req) begin
            state_d   = IDLE;
            start_job = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            issued_q    <= '0;
            recv_q      <= '0;
            eng_start_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            shadow_q    <= '0;
        end else if (flush_req) begin
            issued_q    <= '0;
            recv_q      <= '0;
            eng_start_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            shadow_q    <= '0;
        end else begin
            eng_start_q <= start_job;
            if (start_job) begin
                issued_q <= '0;
                recv_q   <= '0;
            end else begin
                if (in_pop)   issued_q <= issued_q + 16'd1;
                if (out_push) recv_q   <= recv_q + 16'd1;
            end
            // Sticky bits: a new event in the same cycle beats the W1C clear.
            done_q <= job_end || (done_q && !(status_wr && slave_writedata[ST_DONE]));
            ovf_q  <= (in_push_req && in_full && !in_pop) ||
                      (ovf_q && !(status_wr && slave_writedata[ST_OVERFLOW]));
            udf_q  <= (out_pop_req && out_empty) ||
                      (udf_q && !(status_wr && slave_writedata[ST_UNDERFLOW]));
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wr && slave_address == AW'(ADDR_IN_LANE + i))
                    shadow_q[i*DATAWIDTH +: DATAWIDTH] <= slave_writedata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)                                         len_q <= '0;
        else if (wr && slave_address == AW'(ADDR_LEN)) len_q <= slave_writedata[15:0];
    end

    always_comb begin
        status_w                       = '0;
        status_w[ST_IN_EMPTY]          = in_empty;
        status_w[ST_IN_FULL]           = in_full;
        status_w[ST_OUT_EMPTY]         = out_empty;
        status_w[ST_OUT_FULL]          = out_full;
        status_w[ST_RUNNING]           = (state_q == RUN);
        status_w[ST_DONE]              = done_q;
        status_w[ST_OVERFLOW]          = ovf_q;
        status_w[ST_UNDERFLOW]         = udf_q;
        status_w[ST_COUNT_LSB +: 8]    = 8'(out_count);
    end

    always_comb begin
        rdata_d = '0;
        if (slave_address == AW'(ADDR_STATUS))      rdata_d = DATAWIDTH'(status_w);
        else if (slave_address == AW'(ADDR_LEN))    rdata_d = DATAWIDTH'(len_q);
        else if (slave_address == AW'(ADDR_ISSUED)) rdata_d = DATAWIDTH'(issued_q);
        for (int unsigned i = 0; i < LANES; i++) begin
            if (slave_address == AW'(ADDR_IN_LANE + i))
                rdata_d = shadow_q[i*DATAWIDTH +: DATAWIDTH];
            if (slave_address == AW'(ADDR_OUT_LANE + i) && !out_empty)
                rdata_d = out_rdata[i*DATAWIDTH +: DATAWIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) readdata_q <= '0;
        else if (rd)  readdata_q <= rdata_d;
    end

    assign slave_readdata = readdata_q;
    assign eng_start      = eng_start_q;

endmodule

// File: tb/tb_csr_stream_buffer.sv
// Directed/randomized bench for csr_stream_buffer with a queue-based model of
// the FIFOs, job counters and sticky status, plus a loopback engine.
module tb_csr_stream_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  slave_address;
    logic [31:0] slave_writedata;
    logic        slave_write, slave_read, slave_chipselect;
    logic [31:0] slave_readdata;
    logic        eng_start;
    logic [63:0] eng_in_data;
    logic        eng_in_valid, eng_in_ready;
    logic [63:0] eng_out_data;
    logic        eng_out_valid, eng_out_ready;

    always #5 clk = ~clk;

    csr_stream_buffer #(
        .SLAVE_ADDRESSWIDTH(5), .DATAWIDTH(32), .WORDWIDTH(64), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .slave_address(slave_address), .slave_writedata(slave_writedata),
        .slave_write(slave_write), .slave_read(slave_read),
        .slave_chipselect(slave_chipselect), .slave_readdata(slave_readdata),
        .eng_start(eng_start), .eng_in_data(eng_in_data),
        .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready),
        .eng_out_data(eng_out_data), .eng_out_valid(eng_out_valid),
        .eng_out_ready(eng_out_ready)
    );

    int unsigned checks = 0, errors = 0;

    logic [63:0] m_in[$], m_out[$], eng_q[$];
    logic [63:0] m_shadow;
    int unsigned m_len, m_issued, m_recv;
    bit          m_running, m_done, m_ovf, m_udf;
    logic [31:0] exp_readdata;
    int unsigned in_stall = 0, out_stall = 0, start_pulses = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = (m_in.size() == 0);
        s[1] = (m_in.size() == DEPTH);
        s[2] = (m_out.size() == 0);
        s[3] = (m_out.size() == DEPTH);
        s[4] = m_running;
        s[5] = m_done;
        s[8] = m_ovf;
        s[9] = m_udf;
        s[23:16] = 8'(m_out.size());
        return s;
    endfunction

    // One clock: drive the engine, check DUT outputs against the model,
    // advance the model by whatever the bus and engine do at this edge.
    task automatic cycle();
        bit exp_valid, exp_ready, in_hs, out_hs, wr_now, rd_now, fl, st, exp_start;
        int pre_in;
        logic [4:0]  a;
        logic [31:0] d;
        eng_in_ready = ($urandom_range(99) >= in_stall);
        if (eng_q.size() > 0 && $urandom_range(99) >= out_stall) begin
            eng_out_valid = 1'b1;
            eng_out_data  = eng_q[0];
        end else begin
            eng_out_valid = 1'b0;
        end
        exp_valid = m_running && m_in.size() > 0 && m_issued < m_len;
        exp_ready = m_running && m_out.size() < DEPTH;
        check("eng_in_valid", eng_in_valid, exp_valid);
        check("eng_out_ready", eng_out_ready, exp_ready);
        if (exp_valid) check("eng_in_data", eng_in_data, m_in[0]);

        wr_now = slave_chipselect && slave_write;
        rd_now = slave_chipselect && slave_read && !slave_write;
        a = slave_address;
        d = slave_writedata;
        exp_start = 1'b0;
        pre_in = m_in.size();

        if (rd_now) begin
            case (a)
                5'd1:    exp_readdata = m_status();
                5'd2:    exp_readdata = {16'b0, m_len[15:0]};
                5'd3:    exp_readdata = {16'b0, m_issued[15:0]};
                5'd8:    exp_readdata = m_shadow[31:0];
                5'd9:    exp_readdata = m_shadow[63:32];
                5'd16:   exp_readdata = (m_out.size() > 0) ? m_out[0][31:0] : 32'h0;
                5'd17:   exp_readdata = (m_out.size() > 0) ? m_out[0][63:32] : 32'h0;
                default: exp_readdata = 32'h0;
            endcase
            if (a == 5'd17) begin
                if (m_out.size() == 0) m_udf = 1'b1;
                else void'(m_out.pop_front());
            end
        end
        if (wr_now && a == 5'd1) begin
            if (d[5]) m_done = 1'b0;
            if (d[8]) m_ovf  = 1'b0;
            if (d[9]) m_udf  = 1'b0;
        end

        in_hs  = exp_valid && eng_in_ready;
        out_hs = exp_ready && eng_out_valid;
        if (in_hs) begin
            eng_q.push_back(m_in.pop_front());
            m_issued++;
        end
        if (out_hs) begin
            m_out.push_back(eng_q.pop_front());
            m_recv++;
            if (m_recv == m_len) begin
                m_running = 1'b0;
                m_done    = 1'b1;
            end
        end

        fl = 1'b0;
        st = 1'b0;
        if (wr_now) begin
            case (a)
                5'd0: begin fl = d[1]; st = d[0] && !d[1]; end
                5'd2: m_len = d[15:0];
                5'd8: m_shadow[31:0] = d;
                5'd9: begin
                    m_shadow[63:32] = d;
                    if (pre_in < DEPTH || in_hs) m_in.push_back({d, m_shadow[31:0]});
                    else m_ovf = 1'b1;
                end
                default: ;
            endcase
        end
        if (st && !m_running && m_len != 0) begin
            m_running = 1'b1;
            m_issued  = 0;
            m_recv    = 0;
            exp_start = 1'b1;
        end
        if (fl) begin
            m_in.delete();
            m_out.delete();
            m_shadow  = '0;
            m_issued  = 0;
            m_recv    = 0;
            m_running = 1'b0;
            m_done    = 1'b0;
            m_ovf     = 1'b0;
            m_udf     = 1'b0;
        end

        @(posedge clk);
        #1;
        check("eng_start", eng_start, exp_start);
        if (eng_start) start_pulses++;
        check("readdata", slave_readdata, exp_readdata);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        slave_chipselect = 1'b1; slave_write = 1'b1;
        slave_address = a; slave_writedata = d;
        cycle();
        slave_chipselect = 1'b0; slave_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        slave_chipselect = 1'b1; slave_read = 1'b1; slave_address = a;
        cycle();
        v = slave_readdata;
        slave_chipselect = 1'b0; slave_read = 1'b0;
    endtask

    task automatic push_word(input logic [63:0] w);
        wr(5'd8, w[31:0]);
        wr(5'd9, w[63:32]);
    endtask

    initial begin
        logic [31:0] v, lo, hi;
        logic [63:0] saved[DEPTH];
        logic [63:0] t5_exp[$];
        logic [63:0] w;
        int unsigned pulses0, pushed, got;

        reset_n = 1'b0;
        slave_address = '0; slave_writedata = '0;
        slave_write = 1'b0; slave_read = 1'b0; slave_chipselect = 1'b0;
        eng_in_ready = 1'b0; eng_out_valid = 1'b0; eng_out_data = '0;
        m_shadow = '0; m_len = 0; m_issued = 0; m_recv = 0;
        m_running = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        exp_readdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_readdata", slave_readdata, 32'h0);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_in_valid", eng_in_valid, 1'b0);
        check("rst_out_ready", eng_out_ready, 1'b0);
        reset_n = 1'b1;

        rd(5'd1, v);
        check("rst_status", v, 32'h5);

        // Two-word loopback job
        wr(5'd2, 32'd2);
        push_word(64'h11112222_33334444);
        push_word(64'h55556666_77778888);
        pulses0 = start_pulses;
        wr(5'd0, 32'h1);
        for (int n = 0; n < 200 && m_running; n++) cycle();
        check("job_start_pulses", start_pulses - pulses0, 1);
        rd(5'd1, v);
        check("job_done_bit", v[5], 1'b1);
        rd(5'd16, v); check("job_w0_lane0", v, 32'h33334444);
        rd(5'd17, v); check("job_w0_lane1", v, 32'h11112222);
        rd(5'd16, v); check("job_w1_lane0", v, 32'h77778888);
        rd(5'd17, v); check("job_w1_lane1", v, 32'h55556666);
        rd(5'd1, v);
        check("job_out_empty", v[2], 1'b1);

        // Overflow with the FSM not running
        wr(5'd1, 32'h20);
        for (int i = 0; i < DEPTH; i++) begin
            saved[i] = {$urandom, $urandom};
            push_word(saved[i]);
        end
        push_word({$urandom, $urandom});
        rd(5'd1, v);
        check("ovf_in_full", v[1], 1'b1);
        check("ovf_sticky", v[8], 1'b1);
        wr(5'd1, 32'h100);
        wr(5'd2, DEPTH);
        wr(5'd0, 32'h1);
        for (int n = 0; n < 400 && m_running; n++) cycle();
        for (int i = 0; i < DEPTH; i++) begin
            rd(5'd16, lo);
            rd(5'd17, hi);
            check("ovf_order", {hi, lo}, saved[i]);
        end

        // Underflow on empty output FIFO, then W1C
        rd(5'd17, v);
        check("udf_data", v, 32'h0);
        rd(5'd1, v);
        check("udf_set", v[9], 1'b1);
        wr(5'd1, 32'h200);
        rd(5'd1, v);
        check("udf_clear", v[9], 1'b0);

        // Long job with engine stalls and concurrent host drain
        in_stall = 30; out_stall = 40;
        wr(5'd1, 32'h20);
        wr(5'd2, DEPTH + 4);
        wr(5'd0, 32'h1);
        pushed = 0; got = 0;
        for (int n = 0; n < 4000 && got < DEPTH + 4; n++) begin
            if (pushed < DEPTH + 4 && m_in.size() < DEPTH &&
                ($urandom_range(1) == 0 || m_out.size() == 0)) begin
                w = {$urandom, $urandom};
                t5_exp.push_back(w);
                push_word(w);
                pushed++;
            end else if (m_out.size() > 0) begin
                rd(5'd16, lo);
                rd(5'd17, hi);
                check("stall_word", {hi, lo}, t5_exp.pop_front());
                got++;
            end else begin
                cycle();
            end
        end
        rd(5'd1, v);
        check("stall_done", v[5], 1'b1);
        check("stall_out_empty", v[2], 1'b1);
        rd(5'd3, v);
        check("stall_issued", v, DEPTH + 4);

        // FLUSH together with START in the middle of a job
        in_stall = 0; out_stall = 100;
        wr(5'd1, 32'h320);
        wr(5'd2, 32'd5);
        for (int i = 0; i < 5; i++) push_word({$urandom, $urandom});
        wr(5'd0, 32'h1);
        for (int n = 0; n < 50 && m_issued < 3; n++) cycle();
        rd(5'd3, v);
        check("flush_pre_issued", v, 32'd3);
        pulses0 = start_pulses;
        wr(5'd0, 32'h3);
        eng_q.delete();
        rd(5'd1, v);
        check("flush_status", v, 32'h5);
        rd(5'd3, v);
        check("flush_issued", v, 32'h0);
        check("flush_no_start", start_pulses - pulses0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_stream_buffer.md
Name: csr_stream_buffer

Overview:
- Parametrised Avalon-MM CSR slave that stages host data words for a streaming crypto engine (3DES/ECC datapath) and collects the engine results for host readback.
- Contains one input FIFO (host to engine) and one output FIFO (engine to host), with configurable word width and depth.
- A job FSM sequences a LEN-word job. Overflow and underflow are reported through sticky status bits.

Parameters:
- SLAVE_ADDRESSWIDTH, 5, CSR word-address width.
- DATAWIDTH, 32, bus data width.
- WORDWIDTH, 64, engine word width. Must be a multiple of DATAWIDTH; LANES = WORDWIDTH/DATAWIDTH, maximum 8.
- DEPTH, 16, entries per FIFO. Power of 2, at least 2.
- ADDRSIZE, $clog2(DEPTH), FIFO pointer width.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-low
- slave_address  in  SLAVE_ADDRESSWIDTH  CSR word address
- slave_writedata  in  DATAWIDTH  write data
- slave_write  in  1  write strobe
- slave_read  in  1  read strobe
- slave_chipselect  in  1  qualifies read/write
- slave_readdata  out  DATAWIDTH  registered read data
- eng_start  out  1  one-cycle pulse at job start
- eng_in_data  out  WORDWIDTH  head of input FIFO
- eng_in_valid  out  1  input word available
- eng_in_ready  in  1  engine accepts word
- eng_out_data  in  WORDWIDTH  engine result
- eng_out_valid  in  1  result available
- eng_out_ready  out  1  output FIFO can accept

Behaviour:
- Reset: slave_readdata=0, eng_start=0, eng_in_valid=0, eng_out_ready=0. Both FIFOs empty; all CSRs 0; FSM in IDLE.
- CSR map (word addresses):
  - 0 CTRL (write-only pulses): bit0 START, bit1 FLUSH.
  - 1 STATUS (RO except W1C bits): bit0 in_empty, bit1 in_full, bit2 out_empty, bit3 out_full, bit4 running, bit5 done (W1C), bit8 overflow (W1C), bit9 underflow (W1C), [23:16] out_count.
  - 2 LEN: [15:0] words per job.
  - 3 ISSUED (RO): [15:0] words sent to the engine.
  - 8..8+LANES-1 IN_LANE[i]: lane i = bits [DATAWIDTH*(i+1)-1 : DATAWIDTH*i].
  - 16..16+LANES-1 OUT_LANE[i]: same lane mapping.
  - Unmapped addresses read 0 and ignore writes.
- Read latency: exactly 1 cycle. slave_readdata updates only on a chipselected read and holds otherwise.
- A write and a read in the same cycle: the write takes priority and the read is ignored.
- Input push:
  - Writes to IN_LANE[i] load a lane shadow register.
  - A write to IN_LANE[LANES-1] pushes {that write, shadow lanes} in the same cycle.
  - Push while in_full: word dropped, overflow set.
  - Push while full with a simultaneous engine pop: push accepted.
- Output pop:
  - Reads of OUT_LANE[i] return lane i of the output FIFO head.
  - A read of OUT_LANE[LANES-1] pops after the read.
  - Pop while out_empty: returns 0, underflow set, pointers unchanged.
- FIFOs: first-word-fall-through. Count is ADDRSIZE+1 bits; pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
- FSM states IDLE, RUN, DONE:
  - IDLE: START with LEN!=0 → RUN. ISSUED and recv are cleared, eng_start pulses for 1 cycle. START with LEN=0 is ignored.
  - RUN:
    - eng_in_valid = !in_empty && ISSUED<LEN.
    - On an input handshake: pop the input FIFO, ISSUED++.
    - eng_out_ready = !out_full; on an output handshake: push, recv++.
    - When recv reaches LEN → DONE (same cycle as the final push).
    - START in RUN is ignored.
    - Output handshakes in IDLE/DONE are not accepted (eng_out_ready=0).
  - DONE: done=1, running=0. START with LEN!=0 → RUN (new job); done is held until W1C.
  - FLUSH from any state: → IDLE next cycle, both FIFOs emptied, lane shadows, ISSUED, recv and sticky bits cleared. FLUSH takes priority over START when both are written.
- eng_in_data is valid whenever eng_in_valid=1 and is stable until the handshake.
- reset_n low mid-job: everything returns to reset values on the next edge; no partial state retained.

Decomposition:
- Package csr_stream_pkg: state_t enum (IDLE, RUN, DONE); CSR address constants; STATUS bit-index constants.
- Sub-module sync_fifo (WIDTH, DEPTH): FWFT, push/pop/full/empty/count; instantiated twice.

Test Plan:
- Reset, then read STATUS → 0x00000005 (in_empty, out_empty), slave_readdata valid 1 cycle after the read.
- LEN=2; push words 0x11112222_33334444 and 0x55556666_77778888; START; engine loopback with eng_in_ready=1 → eng_start pulses once.
  - DONE is reached and STATUS bit5=1.
  - Lane reads return 0x33334444, 0x11112222, then the second word.
  - out_empty=1 afterwards.
- Push DEPTH+1 words with the FSM idle → in_full=1, overflow=1, count=DEPTH. First DEPTH words are intact in order.
- Read OUT_LANE[LANES-1] with the output FIFO empty → 0x0, underflow=1. W1C bit9 → underflow=0.
- Stall eng_out_valid mid-job with LEN=DEPTH+4 and host draining concurrently → no word lost or duplicated; ordering preserved.
- Job running with 3 words issued; write FLUSH and START together → IDLE, all counts 0, eng_start not pulsed.
